inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the instruction-fetch response path and the decode stage.
- Buffers fetched (pc, instruction) pairs and presents the head entry to decode, together with its pre-split fields (opcode, funct3, funct7, rd, rs1, rs2).
- Drives the `ce` enable of the per-opcode instruction identifiers.
- Absorbs fetch/decode rate mismatch and discards wrong-path instructions on flush.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- XLEN, 32, instruction and pc width.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  branch/jump redirect; empties the queue.
- in_valid  input  1  fetch presents a valid instruction.
- in_ready  output  1  queue can accept this cycle.
- in_pc  input  XLEN  pc of the incoming instruction.
- in_inst  input  XLEN  incoming instruction word.
- out_valid  output  1  head entry valid; also serves as identifier ce (`On` when 1).
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  XLEN  pc of the head entry.
- out_inst  output  XLEN  head instruction word.
- out_opcode  output  7  out_inst[6:0].
- out_rd  output  5  out_inst[11:7].
- out_funct3  output  3  out_inst[14:12].
- out_rs1  output  5  out_inst[19:15].
- out_rs2  output  5  out_inst[24:20].
- out_funct7  output  7  out_inst[31:25].
- count  output  clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - wr_ptr, rd_ptr: log2(DEPTH) bits each; wrap naturally from DEPTH-1 to 0.
  - occupancy counter.
  - DEPTH-entry storage of {pc, inst}.
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0, out_valid = 0, in_ready = 1.
  - Storage contents are don't-care.
- Push:
  - push = in_valid & in_ready & ~flush.
  - Writes {in_pc, in_inst} at wr_ptr; wr_ptr increments.
- Pop:
  - pop = out_valid & out_ready.
  - rd_ptr increments.
- Flow control:
  - in_ready = (count != DEPTH). A full queue does not accept a push even when a pop occurs in the same cycle; there is no full-bypass.
  - out_valid = (count != 0) & ~flush.
- Latency:
  - An instruction pushed at edge N is visible on out_* after edge N.
  - There is no empty-queue bypass: minimum in-to-out latency is 1 cycle.
- Count update per edge:
  - +1 on push only, -1 on pop only, unchanged on push & pop.
  - Never exceeds DEPTH and never underflows.
- Head outputs:
  - Combinational read of storage[rd_ptr]; field outputs are pure slices of out_inst.
  - When count == 0, out_inst = 32'h00000013 (NOP) and out_pc = 0, so downstream identifiers see ADDI x0,x0,0 rather than X.
- Flush (priority over push and pop):
  - At the next edge, wr_ptr = rd_ptr = 0 and count = 0.
  - An in_valid asserted during the flush cycle is dropped.
  - out_valid is 0 during the flush cycle, so decode must not consume then.
  - in_ready follows the pre-flush count.
- Reset mid-operation: contents are lost immediately; no entry survives.
- Stall: with out_ready low, the head entry and all out_* hold stable while out_valid = 1.
- Assertions (simulation only):
  - No push when count == DEPTH.
  - No pop when count == 0.

Decomposition:
- Shared defines header (alongside existing `On`/`funct3_width`/`funct7_width`):
  - Instruction field bit positions and widths: opcode, rd, funct3, rs1, rs2, funct7.
  - `NOP_INST` = 32'h00000013.
- One natural sub-module: inst_field_split, a purely combinational slicer from a 32-bit instruction to opcode/rd/funct3/rs1/rs2/funct7. Decode reuses it elsewhere.
- Queue pointers and storage stay in this block.

Test Plan:
- Reset, then idle → out_valid = 0, in_ready = 1, count = 0, out_inst = 0x00000013.
- Push pc=0x100 inst=0x00500093 (addi x1,x0,5) with out_ready = 0 → next cycle: out_valid = 1, out_opcode = 0x13, out_rd = 1, out_funct3 = 0, out_rs1 = 0, count = 1.
- Push 4 entries with out_ready = 0 → in_ready = 0 after the 4th. Push a 5th with in_valid = 1 plus simultaneous pop → 5th rejected, count = 3. Drain → pcs emerge in order 0x100, 0x104, 0x108, 0x10C.
- Continuous push & pop for 10 cycles across the pointer wrap → count stays 1, order preserved, no loss.
- count = 3 with flush = 1, in_valid = 1, out_ready = 1 in the same cycle → out_valid = 0 that cycle; next cycle count = 0, out_valid = 0; new push afterwards appears as head.
- Assert rst_n low mid-burst with count = 2 → outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue and the decode-side
// field slicer: RV32 instruction field positions/widths and the NOP word.
package inst_fetch_queue_pkg;

    localparam logic ON = 1'b1;

    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_WIDTH = 7;
    localparam int RD_LSB       = 7;
    localparam int RD_WIDTH     = 5;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_WIDTH = 3;
    localparam int RS1_LSB      = 15;
    localparam int RS1_WIDTH    = 5;
    localparam int RS2_LSB      = 20;
    localparam int RS2_WIDTH    = 5;
    localparam int FUNCT7_LSB   = 25;
    localparam int FUNCT7_WIDTH = 7;

    // ADDI x0,x0,0 -- what decode sees when the queue holds nothing.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_queue_field_split.sv
// Purely combinational slicer from a 32-bit RV32 instruction word to its
// fixed-position fields. Shared with the decode stage.
module inst_field_split
    import inst_fetch_queue_pkg::*;
(
    input  logic [31:0]             inst,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [RD_WIDTH-1:0]     rd,
    output logic [FUNCT3_WIDTH-1:0] funct3,
    output logic [RS1_WIDTH-1:0]    rs1,
    output logic [RS2_WIDTH-1:0]    rs2,
    output logic [FUNCT7_WIDTH-1:0] funct7
);

    assign opcode = inst[OPCODE_LSB +: OPCODE_WIDTH];
    assign rd     = inst[RD_LSB     +: RD_WIDTH];
    assign funct3 = inst[FUNCT3_LSB +: FUNCT3_WIDTH];
    assign rs1    = inst[RS1_LSB    +: RS1_WIDTH];
    assign rs2    = inst[RS2_LSB    +: RS2_WIDTH];
    assign funct7 = inst[FUNCT7_LSB +: FUNCT7_WIDTH];

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between the fetch response path and decode. Holds
// (pc, inst) pairs, presents the head with its pre-split fields, and drives
// out_valid as the identifier enable. Flush discards everything queued.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic [OPCODE_WIDTH-1:0]    out_opcode,
    output logic [RD_WIDTH-1:0]        out_rd,
    output logic [FUNCT3_WIDTH-1:0]    out_funct3,
    output logic [RS1_WIDTH-1:0]       out_rs1,
    output logic [RS2_WIDTH-1:0]       out_rs2,
    output logic [FUNCT7_WIDTH-1:0]    out_funct7,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [XLEN-1:0]  inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             empty;
    logic             push;
    logic             pop;

    // Handshakes. A full queue refuses input even if the head leaves this
    // cycle, and flush masks both sides so nothing moves while redirecting.
    assign empty     = (count_q == '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = ~empty & ~flush;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    // Storage needs no reset; an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop in the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head read; an empty queue shows a NOP at pc 0 instead of stale data.
    always_comb begin
        out_pc   = '0;
        out_inst = XLEN'(NOP_INST);
        if (!empty) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end
    end

    inst_field_split u_split (
        .inst   (out_inst[31:0]),
        .opcode (out_opcode),
        .rd     (out_rd),
        .funct3 (out_funct3),
        .rs1    (out_rs1),
        .rs2    (out_rs2),
        .funct7 (out_funct7)
    );

    // The handshake logic should make overflow and underflow impossible.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));

endmodule
